// File: rtl/fb_scan_reader.sv
// Frame-buffer scan-out: 640x480@60 raster timing, SCALE x SCALE upscaled RAM reads,
// and RGB/sync outputs aligned to the RAM's one-cycle registered read.
module fb_scan_reader #(
    parameter int ADDR_WIDTH = 13,
    parameter int DATA_WIDTH = 12,
    parameter int FB_W       = 80,
    parameter int SCALE      = 8,
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [ADDR_WIDTH-1:0] base_addr,
    output logic [ADDR_WIDTH-1:0] read_addr,
    input  logic [DATA_WIDTH-1:0] ram_dout,
    output logic [DATA_WIDTH-1:0] rgb,
    output logic                  hsync,
    output logic                  vsync,
    output logic                  de,
    output logic                  frame_start
);
    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW = $clog2(H_TOTAL);
    localparam int VW = $clog2(V_TOTAL);
    localparam int SW = (SCALE > 1) ? $clog2(SCALE) : 1;

    localparam logic [HW-1:0] H_LAST     = HW'(H_TOTAL - 1);
    localparam logic [HW-1:0] H_ACT      = HW'(H_ACTIVE);
    localparam logic [HW-1:0] H_ACT_LAST = HW'(H_ACTIVE - 1);
    localparam logic [HW-1:0] HS_BEG     = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END     = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_LAST     = VW'(V_TOTAL - 1);
    localparam logic [VW-1:0] V_ACT      = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_BEG     = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END     = VW'(V_ACTIVE + V_FP + V_SYNC);
    localparam logic [SW-1:0] S_LAST     = SW'(SCALE - 1);
    localparam logic [ADDR_WIDTH-1:0] ROW_STEP = ADDR_WIDTH'(FB_W);

    logic [HW-1:0]         h_cnt;
    logic [VW-1:0]         v_cnt;
    logic [SW-1:0]         sx;
    logic [SW-1:0]         sy;
    logic [ADDR_WIDTH-1:0] row_base;
    logic [ADDR_WIDTH-1:0] col_addr;
    logic [1:0]            de_p;
    logic [1:0]            hs_p;
    logic [1:0]            vs_p;
    logic [1:0]            fs_p;

    logic line_end, frame_end, active, act_end, hs0, vs0, fs0;

    always_comb begin
        line_end  = (h_cnt == H_LAST);
        frame_end = line_end && (v_cnt == V_LAST);
        active    = (h_cnt < H_ACT) && (v_cnt < V_ACT);
        act_end   = (h_cnt == H_ACT_LAST) && (v_cnt < V_ACT);
        hs0       = !((h_cnt >= HS_BEG) && (h_cnt < HS_END));
        vs0       = !((v_cnt >= VS_BEG) && (v_cnt < VS_END));
        fs0       = (h_cnt == '0) && (v_cnt == '0);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt       <= '0;
            v_cnt       <= '0;
            sx          <= '0;
            sy          <= '0;
            row_base    <= base_addr;
            col_addr    <= base_addr;
            read_addr   <= '0;
            de_p        <= '0;
            hs_p        <= 2'b11;
            vs_p        <= 2'b11;
            fs_p        <= '0;
            rgb         <= '0;
            de          <= 1'b0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            h_cnt <= line_end ? '0 : h_cnt + 1'b1;
            if (line_end) v_cnt <= frame_end ? '0 : v_cnt + 1'b1;

            read_addr <= active ? col_addr : row_base;

            // The line-end case wins over the per-pixel step: the last pixel of a
            // line always has sx==SCALE-1, and the next line restarts at its row.
            if (frame_end) begin
                row_base <= base_addr;
                col_addr <= base_addr;
                sx       <= '0;
                sy       <= '0;
            end else if (act_end) begin
                sx <= '0;
                if (sy == S_LAST) begin
                    sy       <= '0;
                    row_base <= row_base + ROW_STEP;
                    col_addr <= row_base + ROW_STEP;
                end else begin
                    sy       <= sy + 1'b1;
                    col_addr <= row_base;
                end
            end else if (active) begin
                if (sx == S_LAST) begin
                    sx       <= '0;
                    col_addr <= col_addr + 1'b1;
                end else begin
                    sx <= sx + 1'b1;
                end
            end

            // Two delay stages plus the output register match address + RAM latency.
            de_p <= {de_p[0], active};
            hs_p <= {hs_p[0], hs0};
            vs_p <= {vs_p[0], vs0};
            fs_p <= {fs_p[0], fs0};

            rgb         <= de_p[1] ? ram_dout : '0;
            de          <= de_p[1];
            hsync       <= hs_p[1];
            vsync       <= vs_p[1];
            frame_start <= fs_p[1];
        end
    end
endmodule
